// File: rtl/compressor_pkg.sv
// Shared definitions for the 8-word compress/decompress pair: record geometry,
// the per-word tag encoding and the payload byte size each tag implies.
package compressor_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned NUM_DATA   = 8;
  localparam int unsigned TAG_WIDTH  = 2;
  localparam int unsigned LEN_WIDTH  = 8;
  localparam int unsigned OFF_WIDTH  = 6;

  typedef enum logic [TAG_WIDTH-1:0] {
    TAG_ZERO = 2'b00,
    TAG_B8   = 2'b01,
    TAG_B16  = 2'b10,
    TAG_RAW  = 2'b11
  } tag_e;

  function automatic logic [2:0] tag_size(input tag_e tag);
    case (tag)
      TAG_ZERO: return 3'd0;
      TAG_B8:   return 3'd1;
      TAG_B16:  return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/eight_data_decompress_unit_word_extractor.sv
// Pulls one word out of a packed payload: shift down to the word's byte offset,
// then keep only as many low bytes as the tag says were stored.
module word_extractor
  import compressor_pkg::*;
(
  input  logic [DATA_WIDTH*NUM_DATA-1:0] payload_i,
  input  logic [OFF_WIDTH-1:0]           offset_i,
  input  tag_e                           tag_i,
  output logic [DATA_WIDTH-1:0]          word_o
);

  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] mask;

  always_comb begin
    shifted = DATA_WIDTH'(payload_i >> {offset_i, 3'b000});
    case (tag_i)
      TAG_ZERO: mask = '0;
      TAG_B8:   mask = 32'h0000_00FF;
      TAG_B16:  mask = 32'h0000_FFFF;
      default:  mask = '1;
    endcase
    word_o = shifted & mask;
  end

endmodule

// File: rtl/eight_data_decompress_unit.sv
// Two-stage decompressor: stage 1 captures the record plus per-word byte offsets
// and the length check, stage 2 extracts and registers the 8 output words.
module eight_data_decompress_unit
  import compressor_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_WIDTH*NUM_DATA-1:0] in_payload,
  input  logic [TAG_WIDTH*NUM_DATA-1:0]  in_tag,
  input  logic [LEN_WIDTH-1:0]           in_len,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WIDTH*NUM_DATA-1:0] out_data,
  output logic                           out_err
);

  logic                           s1_valid_q, s1_valid_d;
  logic                           s2_valid_q, s2_valid_d;
  logic                           s1_load, s2_load;
  logic [DATA_WIDTH*NUM_DATA-1:0] payload_q;
  logic [TAG_WIDTH*NUM_DATA-1:0]  tag_q;
  logic [OFF_WIDTH-1:0]           off_d [NUM_DATA];
  logic [OFF_WIDTH-1:0]           off_q [NUM_DATA];
  logic [OFF_WIDTH-1:0]           total;
  logic                           err1_d, err1_q;
  logic [DATA_WIDTH*NUM_DATA-1:0] ext_word;
  logic [DATA_WIDTH*NUM_DATA-1:0] out_data_q;
  logic                           out_err_q;

  // Offsets are an exclusive prefix sum of tag sizes; total is the full sum.
  always_comb begin
    logic [OFF_WIDTH-1:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < NUM_DATA; i++) begin
      off_d[i] = acc;
      acc = acc + OFF_WIDTH'(tag_size(tag_e'(in_tag[i*TAG_WIDTH +: TAG_WIDTH])));
    end
    total  = acc;
    err1_d = (in_len != LEN_WIDTH'(total));
  end

  // in_ready looks through stage 2 so a full pipe still accepts every cycle.
  always_comb begin
    s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
    in_ready = !s1_valid_q || s2_load;
    s1_load  = in_valid && in_ready;
    s1_valid_d = s1_load ? 1'b1 : (s2_load ? 1'b0 : s1_valid_q);
    s2_valid_d = s2_load ? 1'b1 : (out_ready ? 1'b0 : s2_valid_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      payload_q  <= '0;
      tag_q      <= '0;
      off_q      <= '{default: '0};
      err1_q     <= 1'b0;
      out_data_q <= '0;
      out_err_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (s1_load) begin
        payload_q <= in_payload;
        tag_q     <= in_tag;
        off_q     <= off_d;
        err1_q    <= err1_d;
      end
      if (s2_load) begin
        out_data_q <= ext_word;
        out_err_q  <= err1_q;
      end
    end
  end

  for (genvar g = 0; g < NUM_DATA; g++) begin : g_ext
    word_extractor u_ext (
      .payload_i (payload_q),
      .offset_i  (off_q[g]),
      .tag_i     (tag_e'(tag_q[g*TAG_WIDTH +: TAG_WIDTH])),
      .word_o    (ext_word[g*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  always_comb begin
    out_valid = s2_valid_q;
    out_data  = out_data_q;
    out_err   = out_err_q;
  end

endmodule

// File: doc/eight_data_decompress_unit.md
Name: eight_data_decompress_unit

Overview:
- Inverse of the 8-word compress unit. Accepts one compressed record per handshake: packed payload, 8 per-word tags and a byte length.
- Reconstructs the 8 original 32-bit words.
- Sits after the record FIFO that follows the de-aligner in the decompression path, and feeds the output FIFO.
- Two-stage valid/ready pipeline, one record per cycle sustained.

Parameters:
- DATA_WIDTH, 32, width of one uncompressed word.
- NUM_DATA, 8, words per record.
- TAG_WIDTH, 2, tag bits per word.
- LEN_WIDTH, 8, width of the payload byte-length field.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  record present.
- in_ready  out  1  record accepted when in_valid && in_ready.
- in_payload  in  DATA_WIDTH*NUM_DATA  packed payload; word 0 occupies the least-significant bytes; bytes are contiguous.
- in_tag  in  TAG_WIDTH*NUM_DATA  tag of word i at [2i+1:2i].
- in_len  in  LEN_WIDTH  payload length in bytes.
- out_valid  out  1  decoded record present.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_data  out  DATA_WIDTH*NUM_DATA  word i at [32i+31:32i].
- out_err  out  1  length mismatch flag, qualified by out_valid.

Behaviour:
- Tag encoding (fixed):
  - 00 = zero word, 0 payload bytes.
  - 01 = 8-bit value zero-extended, 1 byte.
  - 10 = 16-bit value zero-extended, 2 bytes.
  - 11 = raw 32-bit word, 4 bytes.
- Byte offset of word i = sum of sizes of words 0..i-1 (6-bit prefix sum, max 28). Total size = sum of all 8 sizes (max 32).
- Stage 1 (on accept):
  - Registers payload and tags.
  - Registers the 8 offsets, computed combinationally from in_tag.
  - Registers err1 = (total != in_len). in_len > 32 always sets err.
- Stage 2:
  - Extracts each word from payload at byte offset[i], zero-extended per tag. Tag 00 yields 0 regardless of payload.
  - Registers out_data and out_err.
- Payload bytes at or beyond total are ignored.
- On an err record, data is still decoded from the tags and emitted. The record is never dropped.
- Latency: exactly 2 cycles from input accept to out_valid, when out_ready stays high.
- Flow control, per stage (s1_valid, s2_valid):
  - s2 loads when s1_valid && (!s2_valid || out_ready).
  - s1 loads when in_valid && in_ready.
  - in_ready = !s1_valid || s2 loads this cycle. This is a combinational path from out_ready; no bubble at full throughput.
  - Simultaneous drain and load of the same stage in one cycle is legal and loses nothing.
- Backpressure:
  - With out_ready low, at most 2 records are held, then in_ready = 0.
  - out_data and out_err hold stable while out_valid && !out_ready.
- Reset values:
  - s1_valid = s2_valid = 0, so out_valid = 0.
  - out_data = 0, out_err = 0, internal registers = 0.
  - in_ready = 1 in the first cycle after reset deassertion.
- Reset mid-operation discards all in-flight records. No partial output appears after reset.
- Records are emitted in acceptance order.

Decomposition:
- Package compressor_pkg:
  - DATA_WIDTH, NUM_DATA, TAG_WIDTH, LEN_WIDTH constants.
  - Tag encodings TAG_ZERO=2'b00, TAG_B8=2'b01, TAG_B16=2'b10, TAG_RAW=2'b11.
  - Function tag_size(tag) returning 0/1/2/4.
  - Shared with the compress unit so both ends agree on the encoding.
- Sub-module word_extractor:
  - Combinational; 8 instances in stage 2.
  - Inputs: payload, 6-bit byte offset, tag. Output: one 32-bit word.
  - Implemented as a byte-shift followed by a mask.

Test Plan:
- All tags 00, in_len=0, payload=all 1s -> two cycles later out_data=0 (all 8 words), out_err=0.
- Tag word0=11, others 00, in_payload[31:0]=0xDEADBEEF, in_len=4 -> word0=0xDEADBEEF, words1..7=0, out_err=0.
- Tags w0=01, w1=10, w2=11, rest 00; payload[7:0]=0x12, [23:8]=0x3456, [55:24]=0x89ABCDEF; in_len=7 -> words 0x00000012, 0x00003456, 0x89ABCDEF, rest 0, out_err=0. Repeat with in_len=8 -> same data, out_err=1.
- Push 4 distinct records back-to-back with out_ready=0 for 6 cycles:
  - in_ready falls after 2 accepts.
  - out_data is stable throughout.
  - Raise out_ready: all 4 records emitted in order, one per cycle, none lost or duplicated.
- Random tags and payloads for 1000 records, out_ready and in_valid toggled randomly -> matches the reference model built from the compress encoding.
- Assert reset for 1 cycle while 2 records are in flight -> next cycle out_valid=0, in_ready=1, out_data=0, and no stale record is emitted afterwards.
